// File: rtl/fifo_rr_sched_pkg.sv
// Shared types and helpers for the round-robin FIFO drain scheduler.
package fifo_rr_sched_pkg;

  typedef enum logic {
    ARB,
    BURST
  } state_t;

  // Source index width; a two-input scheduler still needs one bit.
  function automatic int calc_swidth(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_sched_if.sv
// FIFO-bank side and consumer side signals of the scheduler, bundled together.
interface fifo_rr_sched_if
  import fifo_rr_sched_pkg::*;
#(
  parameter int N      = 4,
  parameter int DWIDTH = 8,
  parameter int SWIDTH = calc_swidth(N)
);

  logic [N-1:0]        fifo_rdy;
  logic [N*DWIDTH-1:0] fifo_dout;
  logic [N-1:0]        fifo_pop;
  logic                out_valid;
  logic [DWIDTH-1:0]   out_data;
  logic [SWIDTH-1:0]   out_src;
  logic                out_ready;

  modport master (
    input  fifo_rdy, fifo_dout, out_ready,
    output fifo_pop, out_valid, out_data, out_src
  );

  modport slave (
    output fifo_rdy, fifo_dout, out_ready,
    input  fifo_pop, out_valid, out_data, out_src
  );

endinterface

// File: rtl/fifo_rr_sched_rr_pick.sv
// Combinational rotate-priority picker: first set request above 'last', wrapping at N.
module rr_pick
  import fifo_rr_sched_pkg::*;
#(
  parameter int N      = 4,
  parameter int SWIDTH = calc_swidth(N)
) (
  input  logic [N-1:0]      req,
  input  logic [SWIDTH-1:0] last,
  output logic              found,
  output logic [SWIDTH-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(last) + k) % N]) begin
        found = 1'b1;
        idx   = SWIDTH'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_sched.sv
// Round-robin scheduler draining N FIFOs in bursts of up to BURST words into a
// one-entry output stage tagged with the source index.
module fifo_rr_sched
  import fifo_rr_sched_pkg::*;
#(
  parameter  int N      = 4,
  parameter  int DWIDTH = 8,
  parameter  int BURST  = 4,
  localparam int SWIDTH = calc_swidth(N)
) (
  input logic             clk,
  input logic             reset_n,
  fifo_rr_sched_if.master bus
);

  localparam int CWIDTH = $clog2(BURST + 1);

  // The BURST parameter shadows the enum literal, so states are package-qualified.
  state_t state, state_next;

  logic [SWIDTH-1:0] grant;
  logic [SWIDTH-1:0] last_grant;
  logic [SWIDTH-1:0] pick_idx;
  logic              pick_found;
  logic [CWIDTH-1:0] burst_cnt;
  logic              valid_q;
  logic [DWIDTH-1:0] data_q;
  logic [SWIDTH-1:0] src_q;
  logic              can_take;
  logic              rdy_granted;
  logic              pop_en;
  logic              burst_last;

  rr_pick #(
    .N      (N),
    .SWIDTH (SWIDTH)
  ) u_pick (
    .req   (bus.fifo_rdy),
    .last  (last_grant),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign can_take    = ~valid_q | bus.out_ready;
  assign rdy_granted = bus.fifo_rdy[grant];
  assign pop_en      = (state == fifo_rr_sched_pkg::BURST) && rdy_granted && can_take;
  assign burst_last  = (burst_cnt == CWIDTH'(BURST - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= fifo_rr_sched_pkg::ARB;
    end else begin
      state <= state_next;
    end
  end

  // A stalled output stage holds the burst open; only a drained source or a full burst ends it.
  always_comb begin
    state_next   = state;
    bus.fifo_pop = '0;
    case (state)
      fifo_rr_sched_pkg::ARB: begin
        if (pick_found) begin
          state_next = fifo_rr_sched_pkg::BURST;
        end
      end
      fifo_rr_sched_pkg::BURST: begin
        if (pop_en) begin
          bus.fifo_pop[grant] = 1'b1;
        end
        if ((pop_en && burst_last) || (can_take && !rdy_granted)) begin
          state_next = fifo_rr_sched_pkg::ARB;
        end
      end
      default: state_next = fifo_rr_sched_pkg::ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grant      <= '0;
      last_grant <= SWIDTH'(N - 1);
      burst_cnt  <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      src_q      <= '0;
    end else begin
      if (state == fifo_rr_sched_pkg::ARB && pick_found) begin
        grant      <= pick_idx;
        last_grant <= pick_idx;
        burst_cnt  <= '0;
      end
      if (pop_en) begin
        burst_cnt <= burst_cnt + CWIDTH'(1);
        data_q    <= bus.fifo_dout[grant*DWIDTH +: DWIDTH];
        src_q     <= grant;
        valid_q   <= 1'b1;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Bench for fifo_rr_sched (N=4, DWIDTH=8, BURST=2): FIFO model, scoreboard and vector tables.
module tb_fifo_rr_sched;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int BURST = 2;
  localparam int SW    = 2;

  typedef struct {
    logic         ready;
    logic         exp_valid;
    logic [7:0]   exp_data;
    logic [1:0]   exp_src;
    logic [N-1:0] exp_pop;
  } cyc_vec_t;

  typedef struct {
    logic [1:0] src;
    logic [7:0] data;
  } out_vec_t;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  fifo_rr_sched_if #(.N(N), .DWIDTH(DW), .SWIDTH(SW)) bus ();

  fifo_rr_sched #(.N(N), .DWIDTH(DW), .BURST(BURST)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] mem [N][256];
  int         head [N];
  int         cnt [N];
  int         pop_total [N];
  logic [N-1:0] gate;
  logic [9:0] sb [$];
  logic [9:0] obs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      bus.fifo_rdy[i]          = gate[i] && (cnt[i] > 0);
      bus.fifo_dout[i*DW +: DW] = mem[i][head[i]];
    end
  endtask

  task automatic push_word(input int i, input logic [7:0] v);
    mem[i][(head[i] + cnt[i]) % 256] = v;
    cnt[i]++;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      head[i]      = 0;
      cnt[i]       = 0;
      pop_total[i] = 0;
    end
    gate = '1;
    sb.delete();
    obs.delete();
  endtask

  // Called at a falling edge: checks this cycle's pops/handshake, then advances past the next rising edge.
  task automatic applyStimulus();
    logic [N-1:0] pops;
    logic         can_take;
    logic         in_reset;
    logic         bad;
    logic [9:0]   got;
    pops     = bus.fifo_pop;
    can_take = !bus.out_valid || bus.out_ready;
    in_reset = !reset_n;
    bad      = ($countones(pops) > 1);
    for (int i = 0; i < N; i++) begin
      if (pops[i] && !(bus.fifo_rdy[i] && can_take)) bad = 1'b1;
    end
    check("pop_rule", 32'(bad), 32'd0);
    if (!in_reset && bus.out_valid && bus.out_ready) begin
      got = {bus.out_src, bus.out_data};
      obs.push_back(got);
      if (sb.size() > 0) check("out_word", 32'(got), 32'(sb.pop_front()));
      else               check("out_word_unexpected", 32'(got), 'x);
    end
    for (int i = 0; i < N; i++) begin
      if (pops[i]) begin
        pop_total[i]++;
        sb.push_back({2'(i), mem[i][head[i]]});
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (pops[i] && cnt[i] > 0) begin
        head[i] = (head[i] + 1) % 256;
        cnt[i]--;
      end
    end
    if (in_reset) sb.delete();
    drive_inputs();
  endtask

  task automatic tick();
    @(negedge clk);
    applyStimulus();
  endtask

  task automatic checkOutput(input cyc_vec_t v, input string tag, input int k);
    check($sformatf("%s_valid[%0d]", tag, k), 32'(bus.out_valid), 32'(v.exp_valid));
    check($sformatf("%s_pop[%0d]", tag, k), 32'(bus.fifo_pop), 32'(v.exp_pop));
    if (v.exp_valid) begin
      check($sformatf("%s_data[%0d]", tag, k), 32'(bus.out_data), 32'(v.exp_data));
      check($sformatf("%s_src[%0d]", tag, k), 32'(bus.out_src), 32'(v.exp_src));
    end
  endtask

  task automatic check_obs(input out_vec_t exp_tab[], input string tag);
    check($sformatf("%s_count", tag), 32'(obs.size()), 32'(exp_tab.size()));
    for (int j = 0; j < exp_tab.size(); j++) begin
      if (j < obs.size()) begin
        check($sformatf("%s_src[%0d]", tag, j), 32'(obs[j][9:8]), 32'(exp_tab[j].src));
        check($sformatf("%s_data[%0d]", tag, j), 32'(obs[j][7:0]), 32'(exp_tab[j].data));
      end
    end
  endtask

  // Leaves the bench one nanosecond into the first cycle with reset released.
  task automatic do_reset();
    reset_n       = 1'b0;
    bus.out_ready = 1'b0;
    clear_model();
    drive_inputs();
    tick();
    @(negedge clk);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_src", 32'(bus.out_src), 32'd0);
    check("rst_pop", 32'(bus.fifo_pop), 32'd0);
    applyStimulus();
    reset_n = 1'b1;
  endtask

  initial begin
    cyc_vec_t s1_tab [7];
    cyc_vec_t stall_v;
    out_vec_t s2_tab [];
    out_vec_t s3_tab [];
    out_vec_t s4_tab [];
    out_vec_t s5_tab [];
    int       left;

    s1_tab[0] = '{1'b1, 1'b0, 8'h00, 2'd0, 4'b0000};
    s1_tab[1] = '{1'b1, 1'b0, 8'h00, 2'd0, 4'b0100};
    s1_tab[2] = '{1'b1, 1'b1, 8'hA1, 2'd2, 4'b0100};
    s1_tab[3] = '{1'b1, 1'b1, 8'hA2, 2'd2, 4'b0000};
    s1_tab[4] = '{1'b1, 1'b0, 8'h00, 2'd0, 4'b0100};
    s1_tab[5] = '{1'b1, 1'b1, 8'hA3, 2'd2, 4'b0000};
    s1_tab[6] = '{1'b1, 1'b0, 8'h00, 2'd0, 4'b0000};

    s2_tab = new[12];
    s2_tab = '{'{2'd0, 8'h10}, '{2'd0, 8'h11}, '{2'd1, 8'h20}, '{2'd1, 8'h21},
               '{2'd2, 8'h30}, '{2'd2, 8'h31}, '{2'd3, 8'h40}, '{2'd3, 8'h41},
               '{2'd0, 8'h12}, '{2'd1, 8'h22}, '{2'd2, 8'h32}, '{2'd3, 8'h42}};
    s3_tab = new[3];
    s3_tab = '{'{2'd1, 8'hB1}, '{2'd1, 8'hB2}, '{2'd1, 8'hB3}};
    s4_tab = new[3];
    s4_tab = '{'{2'd3, 8'hD1}, '{2'd0, 8'hC1}, '{2'd3, 8'hD2}};
    s5_tab = new[4];
    s5_tab = '{'{2'd0, 8'hF0}, '{2'd2, 8'hE2}, '{2'd2, 8'hE3}, '{2'd2, 8'hE4}};
    stall_v = '{1'b0, 1'b1, 8'hB1, 2'd1, 4'b0000};

    // Single source: burst of two, one arbitration bubble, then the last word.
    do_reset();
    for (int k = 1; k <= 3; k++) push_word(2, 8'hA0 + 8'(k));
    drive_inputs();
    for (int k = 0; k < 7; k++) begin
      bus.out_ready = s1_tab[k].ready;
      @(negedge clk);
      checkOutput(s1_tab[k], "s1", k);
      applyStimulus();
    end
    check("s1_pops_bit2", 32'(pop_total[2]), 32'd3);
    check("s1_out_count", 32'(obs.size()), 32'd3);

    // Four full sources: rotation order with bursts capped at two.
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) push_word(i, 8'((i + 1) * 16 + k));
    drive_inputs();
    for (int c = 0; c < 80 && obs.size() < 12; c++) tick();
    check_obs(s2_tab, "s2");

    // Output stall holds the first word and suppresses pops.
    do_reset();
    for (int k = 1; k <= 3; k++) push_word(1, 8'hB0 + 8'(k));
    drive_inputs();
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput(stall_v, "s3_stall", k);
      applyStimulus();
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 30 && obs.size() < 3; c++) tick();
    check_obs(s3_tab, "s3");

    // Source 3 drains early; the search from 3 wraps to 0 ahead of 3.
    do_reset();
    bus.out_ready = 1'b1;
    push_word(3, 8'hD1);
    push_word(3, 8'hD2);
    drive_inputs();
    tick();
    tick();
    gate[3] = 1'b0;
    push_word(0, 8'hC1);
    drive_inputs();
    tick();
    gate[3] = 1'b1;
    drive_inputs();
    for (int c = 0; c < 30 && obs.size() < 3; c++) tick();
    check_obs(s4_tab, "s4");

    // Reset mid-burst discards the held word and restarts arbitration at FIFO 0.
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) push_word(2, 8'hE0 + 8'(k));
    drive_inputs();
    tick();
    tick();
    check("s5_valid_before", 32'(bus.out_valid), 32'd1);
    reset_n       = 1'b0;
    bus.out_ready = 1'b0;
    push_word(0, 8'hF0);
    drive_inputs();
    tick();
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("s5_valid_after", 32'(bus.out_valid), 32'd0);
    check("s5_pop_after", 32'(bus.fifo_pop), 32'd0);
    applyStimulus();
    obs.delete();
    for (int c = 0; c < 40 && obs.size() < 4; c++) tick();
    check_obs(s5_tab, "s5");

    // Random readiness and back-pressure, then a bounded drain.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      gate          = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if (cnt[i] < 8 && $urandom_range(0, 1) == 1) push_word(i, 8'($urandom));
      drive_inputs();
      tick();
    end
    gate          = '1;
    bus.out_ready = 1'b1;
    drive_inputs();
    left = 1;
    for (int c = 0; c < 300 && left != 0; c++) begin
      tick();
      left = sb.size() + int'(bus.out_valid);
      for (int i = 0; i < N; i++) left += cnt[i];
    end
    check("rand_sb_empty", 32'(sb.size()), 32'd0);
    check("rand_drained", 32'(left), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
